// File: rtl/ddr_req_arbiter_pkg.sv
// Shared definitions for the DDR2 request arbiter: FSM encodings, port
// indices, command-FIFO codes and write-data beat geometry.
package ddr_req_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CMD    = 2'd1,
        ST_WDATA1 = 2'd2
    } arb_state_t;

    localparam int NUM_PORTS = 3;

    localparam logic [1:0] PORT0 = 2'd0;
    localparam logic [1:0] PORT1 = 2'd1;
    localparam logic [1:0] PORT2 = 2'd2;

    localparam logic [2:0] AF_CMD_WRITE = 3'b000;
    localparam logic [2:0] AF_CMD_READ  = 3'b001;

    localparam int BEAT_W       = 128;
    localparam int MASK_W       = 16;
    localparam int BURST_W      = 2 * BEAT_W;
    localparam int BURST_MASK_W = 2 * MASK_W;

    // One-hot port vector for a port index.
    function automatic logic [NUM_PORTS-1:0] port_onehot(input logic [1:0] p);
        return 3'b001 << p;
    endfunction

endpackage

// File: rtl/ddr_req_arbiter_tag_fifo.sv
// Outstanding-read tag FIFO: remembers which port issued each read so the
// returned read beats can be steered back to it.
module ddr_req_arbiter_tag_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [1:0] push_data,
    input  logic       pop,
    output logic [1:0] head,
    output logic       full,
    output logic       empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [1:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointers and occupancy; a simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Tag storage; contents are meaningless while empty, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/ddr_req_arbiter.sv
// Three-port arbiter in front of the DDR2 controller's af_/wdf_ FIFOs.
// Port0 (pixel feeder) is favoured but limited to P0_MAX_RUN back-to-back
// grants while port1/port2 wait; port1 and port2 alternate round-robin.
// Writes push a command then two 128-bit beats; reads push a command and a
// tag so the returned beats are steered to the issuing port.
module ddr_req_arbiter
    import ddr_req_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 31,
    parameter int TAG_DEPTH  = 8,
    parameter int P0_MAX_RUN = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_PORTS-1:0]          req_valid,
    output logic [NUM_PORTS-1:0]          req_ready,
    input  logic [NUM_PORTS-1:0]          req_we,
    input  logic [NUM_PORTS*ADDR_W-1:0]   req_addr,
    input  logic [NUM_PORTS*BURST_W-1:0]  req_wdata,
    input  logic [NUM_PORTS*BURST_MASK_W-1:0] req_wmask,
    output logic [ADDR_W-1:0]             af_addr_din,
    output logic [2:0]                    af_wr_din,
    output logic                          af_wr_en,
    input  logic                          af_full,
    output logic [BEAT_W-1:0]             wdf_din,
    output logic [MASK_W-1:0]             wdf_mask_din,
    output logic                          wdf_wr_en,
    input  logic                          wdf_full,
    input  logic                          rd_data_valid,
    input  logic [BEAT_W-1:0]             rd_data_fifo_out,
    output logic [BEAT_W-1:0]             rdata,
    output logic [NUM_PORTS-1:0]          rdata_valid,
    output logic                          rdata_last,
    output logic                          tag_err
);

    localparam int RUN_W = $clog2(P0_MAX_RUN + 1);

    arb_state_t              state;
    arb_state_t              state_nxt;
    logic [1:0]              gnt;
    logic [1:0]              win_port;
    logic                    win_valid;
    logic [1:0]              rr_ptr;
    logic [RUN_W-1:0]        run_cnt;
    logic                    p12_pending;
    logic                    p0_blocked;
    logic                    p0_done;
    logic                    p12_done;
    logic                    beat_cnt;
    logic                    rd_hit;
    logic                    tag_push;
    logic                    tag_pop;
    logic                    tag_full;
    logic                    tag_empty;
    logic [1:0]              tag_head;
    logic                    gnt_we;
    logic [ADDR_W-1:0]       gnt_addr;
    logic [BURST_W-1:0]      gnt_wdata;
    logic [BURST_MASK_W-1:0] gnt_wmask;

    // The granted requester holds its fields stable until its ready pulse.
    assign gnt_we    = req_we[gnt];
    assign gnt_addr  = req_addr[gnt*ADDR_W +: ADDR_W];
    assign gnt_wdata = req_wdata[gnt*BURST_W +: BURST_W];
    assign gnt_wmask = req_wmask[gnt*BURST_MASK_W +: BURST_MASK_W];

    assign p12_pending = req_valid[1] | req_valid[2];
    assign p0_blocked  = (run_cnt == RUN_W'(P0_MAX_RUN)) && p12_pending;
    assign p0_done     = req_ready[0];
    assign p12_done    = req_ready[1] | req_ready[2];

    // Winner selection: port0 first unless its run limit is hit, then port1/2 round-robin.
    always_comb begin
        win_valid = 1'b0;
        win_port  = PORT0;
        if (req_valid[0] && !p0_blocked) begin
            win_valid = 1'b1;
            win_port  = PORT0;
        end else if (p12_pending) begin
            win_valid = 1'b1;
            win_port  = req_valid[rr_ptr] ? rr_ptr : ((rr_ptr == PORT1) ? PORT2 : PORT1);
        end
    end

    // FSM state register and latched grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            gnt   <= PORT0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && win_valid) gnt <= win_port;
        end
    end

    // FSM next-state: each stage waits on the FIFO flags it is about to push into.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (win_valid) state_nxt = ST_CMD;
            end
            ST_CMD: begin
                if (gnt_we) begin
                    if (!af_full && !wdf_full) state_nxt = ST_WDATA1;
                end else begin
                    if (!af_full && !tag_full) state_nxt = ST_IDLE;
                end
            end
            ST_WDATA1: begin
                if (!wdf_full) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs: FIFO pushes, tag push and the requester's completion pulse.
    always_comb begin
        af_wr_en     = 1'b0;
        af_wr_din    = AF_CMD_WRITE;
        af_addr_din  = '0;
        wdf_wr_en    = 1'b0;
        wdf_din      = '0;
        wdf_mask_din = '0;
        req_ready    = '0;
        tag_push     = 1'b0;
        case (state)
            ST_CMD: begin
                if (gnt_we) begin
                    if (!af_full && !wdf_full) begin
                        af_wr_en     = 1'b1;
                        af_wr_din    = AF_CMD_WRITE;
                        af_addr_din  = gnt_addr;
                        wdf_wr_en    = 1'b1;
                        wdf_din      = gnt_wdata[BEAT_W-1:0];
                        wdf_mask_din = gnt_wmask[MASK_W-1:0];
                    end
                end else begin
                    if (!af_full && !tag_full) begin
                        af_wr_en    = 1'b1;
                        af_wr_din   = AF_CMD_READ;
                        af_addr_din = gnt_addr;
                        tag_push    = 1'b1;
                        req_ready   = port_onehot(gnt);
                    end
                end
            end
            ST_WDATA1: begin
                if (!wdf_full) begin
                    wdf_wr_en    = 1'b1;
                    wdf_din      = gnt_wdata[BURST_W-1:BEAT_W];
                    wdf_mask_din = gnt_wmask[BURST_MASK_W-1:MASK_W];
                    req_ready    = port_onehot(gnt);
                end
            end
            default: ;
        endcase
    end

    // Fairness bookkeeping: port0 run length and the port1/port2 pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr  <= PORT1;
            run_cnt <= '0;
        end else begin
            if (p12_done) rr_ptr <= (rr_ptr == PORT1) ? PORT2 : PORT1;
            if (p12_done || !p12_pending) begin
                run_cnt <= '0;
            end else if (p0_done && run_cnt != RUN_W'(P0_MAX_RUN)) begin
                run_cnt <= run_cnt + 1'b1;
            end
        end
    end

    // Read return steering: beats only count against a tag when one is outstanding.
    assign rd_hit      = rd_data_valid && !tag_empty;
    assign tag_pop     = rd_hit && beat_cnt;
    assign rdata       = rd_data_fifo_out;
    assign rdata_valid = rd_hit ? port_onehot(tag_head) : '0;
    assign rdata_last  = rd_hit && beat_cnt;

    // Beat parity within a burst and the sticky orphan-beat flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= 1'b0;
            tag_err  <= 1'b0;
        end else begin
            if (rd_hit) beat_cnt <= ~beat_cnt;
            if (rd_data_valid && tag_empty) tag_err <= 1'b1;
        end
    end

    ddr_req_arbiter_tag_fifo #(
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (tag_push),
        .push_data (gnt),
        .pop       (tag_pop),
        .head      (tag_head),
        .full      (tag_full),
        .empty     (tag_empty)
    );

endmodule
